// File: rtl/s_iter.sv
// s_iter: circular set-bit iterator.
// Emits up to P_K indices per beat under valid/ready.
module s_iter #(
  parameter int W      = 8,
  parameter int P_K    = 1,
  parameter bit P_WRAP = 1'b1
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      in_vld_i,
  output logic                      in_rdy_o,
  input  logic [W-1:0]              in_x_i,
  input  logic [$clog2(W)-1:0]      in_pos_i,
  output logic                      out_vld_o,
  input  logic                      out_rdy_i,
  output logic                      out_any_o,
  output logic [P_K-1:0]            out_lane_vld_o,
  output logic [P_K*$clog2(W)-1:0]  out_y_enc_o,
  output logic [W-1:0]              out_y_o,
  output logic                      out_last_o
);

  localparam int LW = $clog2(W);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic [W-1:0]        r_mask;
  logic [LW-1:0]       r_pos;
  logic                r_any;
  logic [P_K-1:0]      r_lane_vld;
  logic [P_K*LW-1:0]   r_y_enc;
  logic [W-1:0]        r_y;
  logic                r_last;

  logic                w_load;
  logic                w_adv;
  logic                w_done;

  logic [W-1:0]        w_in_mask;
  logic [W-1:0]        w_src_mask;
  logic [LW-1:0]       w_src_pos;

  logic [W-1:0]        w_left;
  logic [W-1:0]        w_y;
  logic [LW-1:0]       w_idx;
  logic [LW-1:0]       w_sel;
  logic                w_hit;
  logic [P_K-1:0]      w_lane_vld;
  logic [P_K*LW-1:0]   w_y_enc;
  logic                w_last;

  // Qualify the incoming vector: without wrap, bits below pos are dropped
  always_comb begin
    w_in_mask = in_x_i;
    if (!P_WRAP) begin
      for (int i = 0; i < W; i++) begin
        if (LW'(i) < in_pos_i) begin
          w_in_mask[i] = 1'b0;
        end
      end
    end
  end

  // Beat source: fresh vector when idle, remaining bits while emitting
  always_comb begin
    if (r_state == S_IDLE) begin
      w_src_mask = w_in_mask;
      w_src_pos  = in_pos_i;
    end else begin
      w_src_mask = r_mask & ~r_y;
      w_src_pos  = r_pos;
    end
  end

  // Pick the next P_K set bits in scan order starting at the source pos
  always_comb begin
    w_left     = w_src_mask;
    w_y        = '0;
    w_lane_vld = '0;
    w_y_enc    = '0;
    w_hit      = 1'b0;
    w_sel      = '0;
    w_idx      = '0;
    for (int k = 0; k < P_K; k++) begin
      w_hit = 1'b0;
      w_sel = '0;
      for (int j = 0; j < W; j++) begin
        w_idx = w_src_pos + LW'(j);
        if (!w_hit && w_left[w_idx]) begin
          w_hit = 1'b1;
          w_sel = w_idx;
        end
      end
      if (w_hit) begin
        w_left[w_sel]            = 1'b0;
        w_y[w_sel]               = 1'b1;
        w_lane_vld[k]            = 1'b1;
        w_y_enc[k*LW +: LW]      = w_sel;
      end
    end
    w_last = (w_left == '0);
  end

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state and datapath strobes
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_adv      = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_vld_i) begin
          w_load     = 1'b1;
          w_state_nx = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_rdy_i) begin
          if (r_last) begin
            w_done     = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
    endcase
  end

  // Beat registers: load on accept, advance on handshake, clear at end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mask     <= '0;
      r_pos      <= '0;
      r_any      <= 1'b0;
      r_lane_vld <= '0;
      r_y_enc    <= '0;
      r_y        <= '0;
      r_last     <= 1'b0;
    end else if (w_load || w_adv) begin
      r_mask     <= w_src_mask;
      r_pos      <= w_src_pos;
      r_lane_vld <= w_lane_vld;
      r_y_enc    <= w_y_enc;
      r_y        <= w_y;
      r_last     <= w_last;
      if (w_load) begin
        r_any <= |w_src_mask;
      end
    end else if (w_done) begin
      r_mask     <= '0;
      r_pos      <= '0;
      r_any      <= 1'b0;
      r_lane_vld <= '0;
      r_y_enc    <= '0;
      r_y        <= '0;
      r_last     <= 1'b0;
    end
  end

  assign in_rdy_o       = (r_state == S_IDLE);
  assign out_vld_o      = (r_state == S_EMIT);
  assign out_any_o      = r_any;
  assign out_lane_vld_o = r_lane_vld;
  assign out_y_enc_o    = r_y_enc;
  assign out_y_o        = r_y;
  assign out_last_o     = r_last;

endmodule

// File: doc/s_iter.md
# s_iter

Sequential successor to the combinational circular select block `s`. It accepts a W-bit vector and a start position, then walks every set bit in circular order from that position. Each output beat emits up to P_K bit indices, under valid/ready flow control. It sits between a request-vector source (for example pending-request masks) and a consumer that services one or more indices per cycle. It replaces repeated single-shot `s` lookups with a self-clearing iterator.

## Interface
Parameters:
- W, 8, vector width; power of two, ≥ 2.
- P_K, 1, lanes (indices emitted per beat); 1 ≤ P_K ≤ W.
- P_WRAP, 1, 1 = circular scan (pos → W-1 → 0 → pos-1); 0 = scan pos → W-1 only, bits below pos ignored.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset; one clock, asynchronous, active-low
- in_vld_i  in  1  input transaction valid
- in_rdy_o  out  1  block can accept a transaction
- in_x_i  in  W  request vector
- in_pos_i  in  $clog2(W)  start position
- out_vld_o  out  1  output beat valid
- out_rdy_i  in  1  consumer accepts beat
- out_any_o  out  1  transaction vector (after P_WRAP masking) had ≥ 1 set bit
- out_lane_vld_o  out  P_K  per-lane index valid; always contiguous from lane 0
- out_y_enc_o  out  P_K*$clog2(W)  lane k index at bits [k*$clog2(W) +: $clog2(W)]
- out_y_o  out  W  OR of one-hot decodes of all valid lanes this beat
- out_last_o  out  1  final beat of transaction

## Operation
- State machine with two states: IDLE and EMIT.
- IDLE:
  - in_rdy_o=1.
  - On in_vld_i & in_rdy_o, load mask_r ← in_x_i, masked to bits ≥ in_pos_i when P_WRAP=0.
  - Load pos_r ← in_pos_i.
  - Compute the first beat; go to EMIT.
- EMIT:
  - in_rdy_o=0; out_vld_o=1.
  - Beat content is registered and holds stable until out_rdy_i=1.
  - On handshake with out_last_o=0: clear the emitted bits from mask_r, compute the next beat, stay in EMIT.
  - On handshake with out_last_o=1: go to IDLE.
- Beat computation:
  - Lane 0 holds the first set bit of mask_r in scan order from pos_r; lane k holds the (k+1)-th.
  - Lanes beyond the remaining count have lane_vld=0 and y_enc=0.
  - out_last_o=1 when no bits remain after this beat's bits are removed.
- Empty transaction (masked vector = 0): exactly one beat with out_any_o=0, out_lane_vld_o=0, out_y_o=0, out_last_o=1.
- out_any_o is constant across all beats of a transaction.
- The bit at pos_r itself is first in scan order if set.
- Scan-order arithmetic: relative index (i − pos_r) mod W, in $clog2(W)-bit natural wraparound. Emitted indices are absolute.
- Total beats per transaction = max(1, ceil(popcount/P_K)).
- Back-to-back transactions: no overlap; the next input is accepted at earliest the cycle after the last beat's handshake.

## Timing
- Reset (arst_n=0, asynchronous): state=IDLE, mask_r=0, pos_r=0, in_rdy_o=1, out_vld_o=0, out_any_o=0, out_lane_vld_o=0, out_y_enc_o=0, out_y_o=0, out_last_o=0.
- Reset mid-transaction: the transaction is dropped; outputs are in reset values in the same cycle the reset asserts; no partial beat after release.
- Latency: input handshake in cycle t → first beat valid at t+1.
- Beat throughput: one beat per cycle while out_rdy_i=1.
- in_rdy_o depends only on state; it has no combinational path from out_rdy_i or in_vld_i.
- out_* are driven from registers; no combinational path from in_* to out_*.
- out_rdy_i low: all out_* hold values; mask_r is unchanged.
- in_vld_i in EMIT is ignored. The source must hold in_vld_i and its data until in_rdy_o=1 (standard valid/ready).

## Test plan
- W=8, P_K=2, P_WRAP=1; x=8'b1010_0101, pos=3, out_rdy=1 → beat1 lanes {5,7}, y=8'hA0, last=0; beat2 {0,2}, y=8'h05, last=1; any=1 both beats; in_rdy re-high the next cycle.
- Same stimulus with P_WRAP=0 → single beat {5,7}, last=1, any=1.
- P_K=2; x=8'b0000_1011, pos=1 → beat1 {1,3}, beat2 lane_vld=2'b01 enc 0, last=1. Then x=0 → one beat any=0, lane_vld=0, last=1.
- out_rdy_i low for 3 cycles mid-transaction (x=8'hFF, pos=6, P_K=1: order 6,7,0,...) → outputs frozen at index 7 during the stall, no index skipped or repeated, 8 beats total.
- arst_n pulsed low during beat 2 of x=8'hFF → outputs reset immediately; after release in_rdy=1, out_vld=0; a new transaction x=8'h10, pos=4 → one beat enc 4, last=1.
- Randomised W=16, P_K=3: per transaction, the union of emitted indices equals x (masked), in strict scan order, with beat count ceil(popcount/3).
